// File: rtl/audio_pkg.sv
// Shared defaults and stereo payload layout for the audio sample sink and its producers.
package audio_pkg;

  localparam int unsigned DEFAULT_AUDIO_BITS = 12;
  localparam int unsigned DEFAULT_FRAME_DIV  = 256;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Packed stereo sample: left channel in the upper half, right channel in the lower half.
  typedef struct packed {
    logic [DEFAULT_AUDIO_BITS-1:0] left;
    logic [DEFAULT_AUDIO_BITS-1:0] right;
  } stereo_t;

  localparam int unsigned LEFT_MSB  = 2 * DEFAULT_AUDIO_BITS - 1;
  localparam int unsigned LEFT_LSB  = DEFAULT_AUDIO_BITS;
  localparam int unsigned RIGHT_MSB = DEFAULT_AUDIO_BITS - 1;
  localparam int unsigned RIGHT_LSB = 0;

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order delta-sigma modulator: the registered accumulator carry is the 1-bit output.
module sigma_delta_dac
  import audio_pkg::*;
#(
  parameter int unsigned AUDIO_BITS = DEFAULT_AUDIO_BITS
) (
  input  logic                  clk_audio,
  input  logic                  aclr_,
  input  logic [AUDIO_BITS-1:0] cur,
  output logic                  out
);

  logic [AUDIO_BITS:0] r_acc;

  // Carry is dropped back out of the accumulator each cycle; never cleared at frame edges.
  always_ff @(posedge clk_audio or negedge aclr_) begin
    if (!aclr_) begin
      r_acc <= '0;
      out   <= 1'b0;
    end else begin
      r_acc <= {1'b0, r_acc[AUDIO_BITS-1:0]} + {1'b0, cur};
      out   <= r_acc[AUDIO_BITS];
    end
  end

endmodule

// File: rtl/audio_sample_sink.sv
// Stereo sample responder: FIFO fed by producers, drained one entry per frame tick into two delta-sigma DACs.
module audio_sample_sink
  import audio_pkg::*;
#(
  parameter int unsigned AUDIO_BITS = DEFAULT_AUDIO_BITS,
  parameter int unsigned FRAME_DIV  = DEFAULT_FRAME_DIV,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk_audio,
  input  logic                          aclr_,
  input  logic                          wreq,
  input  logic [2*AUDIO_BITS-1:0]       sample,
  output logic                          ready,
  output logic                          left_out,
  output logic                          right_out,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(FRAME_DIV);
  localparam int unsigned SMP_W = 2 * AUDIO_BITS;

  logic [SMP_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [LVL_W-1:0]      r_level;
  logic [CNT_W-1:0]      r_cnt;
  logic [AUDIO_BITS-1:0] r_cur_l;
  logic [AUDIO_BITS-1:0] r_cur_r;
  logic                  r_underrun;
  logic                  r_overflow;

  logic                  w_ready;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_pop;
  logic [SMP_W-1:0]      w_head;

  // ready depends on the registered level only, so producers see no path from wreq or the tick.
  assign w_ready = (r_level < LVL_W'(FIFO_DEPTH));
  assign w_tick  = (r_cnt == CNT_W'(FRAME_DIV - 1));
  assign w_push  = wreq && w_ready;
  assign w_pop   = w_tick && (r_level != '0);
  assign w_head  = r_mem[r_rptr];

  // Storage holds no reset; contents are discarded by clearing pointers and level.
  always_ff @(posedge clk_audio) begin
    if (w_push) begin
      r_mem[r_wptr] <= sample;
    end
  end

  always_ff @(posedge clk_audio or negedge aclr_) begin
    if (!aclr_) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_cur_l    <= '0;
      r_cur_r    <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);

      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (wreq && !w_ready) begin
        r_overflow <= 1'b1;
      end

      // On an empty tick the current sample is held so the DAC repeats the last value.
      if (w_pop) begin
        r_rptr  <= r_rptr + PTR_W'(1);
        r_cur_l <= w_head[SMP_W-1 -: AUDIO_BITS];
        r_cur_r <= w_head[AUDIO_BITS-1:0];
      end
      if (w_tick && (r_level == '0)) begin
        r_underrun <= 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign ready    = w_ready;
  assign level    = r_level;
  assign underrun = r_underrun;
  assign overflow = r_overflow;

  sigma_delta_dac #(.AUDIO_BITS(AUDIO_BITS)) u_dac_left (
    .clk_audio (clk_audio),
    .aclr_     (aclr_),
    .cur       (r_cur_l),
    .out       (left_out)
  );

  sigma_delta_dac #(.AUDIO_BITS(AUDIO_BITS)) u_dac_right (
    .clk_audio (clk_audio),
    .aclr_     (aclr_),
    .cur       (r_cur_r),
    .out       (right_out)
  );

endmodule
